// File: rtl/acc_drain_requant_pkg.sv
// Shared definitions for the accumulator read-out path.
//   ACC_WIDTH_DEF / OP_WIDTH_DEF : default accumulator and output operand widths
//   drain_state_t                : drain controller state
package acc_drain_requant_pkg;
  localparam int ACC_WIDTH_DEF   = 32;
  localparam int OP_WIDTH_DEF    = 8;
  localparam int SHIFT_WIDTH_DEF = 5;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_t;
endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up right shift, then unsigned
// saturation to OUT_WIDTH. Reusable by any output path.
//   x     : unsigned accumulator value
//   shift : right-shift amount, 0 means no shift and no rounding
//   y     : saturated result
module requant_sat #(
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic [ACC_WIDTH-1:0]   x,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [OUT_WIDTH-1:0]   y
);
  localparam logic [ACC_WIDTH:0] MAX_OUT = {{(ACC_WIDTH+1-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  // One guard bit above ACC_WIDTH so the rounding add can never wrap.
  logic [ACC_WIDTH:0] half;
  logic [ACC_WIDTH:0] sum;
  logic [ACC_WIDTH:0] r;

  always_comb begin
    half = '0;
    if (shift != '0) half = (ACC_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1));
    sum = {1'b0, x} + half;
    r   = sum >> shift;
    y   = (r > MAX_OUT) ? {OUT_WIDTH{1'b1}} : r[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/acc_drain_requant.sv
// Read-out end of the MAC accumulators. A start snapshots all NUM_ACC
// accumulators while clearing the MACs in the same cycle, then streams the
// requantized values out one per cycle.
//   clk, reset            : clock, synchronous active-high reset
//   start                 : drain request, taken only when idle
//   acc_in                : packed accumulators, element i at [i*ACC_WIDTH +: ACC_WIDTH]
//   shift                 : requant shift, latched on accept
//   mac_clear             : combinational clear pulse to the MACs (== accept)
//   busy                  : drain in progress
//   out_valid/out_ready   : output handshake
//   out_data/out_index/out_last : requantized element, its index, last flag
module acc_drain_requant
  import acc_drain_requant_pkg::*;
#(
  parameter int NUM_ACC     = 4,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH   = OP_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  localparam int IDX_W      = $clog2(NUM_ACC)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_ACC*ACC_WIDTH-1:0] acc_in,
  input  logic [SHIFT_WIDTH-1:0]       shift,
  output logic                         mac_clear,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]             out_index,
  output logic                         out_last
);
  drain_state_t                            state;
  logic [NUM_ACC-1:0][ACC_WIDTH-1:0]       buffer;
  logic [SHIFT_WIDTH-1:0]                  shift_q;
  logic                                    accept;
  logic [IDX_W-1:0]                        nxt_index;
  logic [ACC_WIDTH-1:0]                    rq_x;
  logic [SHIFT_WIDTH-1:0]                  rq_shift;
  logic [OUT_WIDTH-1:0]                    rq_y;

  // The MAC clear and the snapshot share one edge, so the snapshot sees the
  // pre-clear values and nothing accumulated is lost.
  assign accept    = start & ~busy & ~reset;
  assign mac_clear = accept;

  // Wrap to 0 on the last element keeps the buffer index in range for
  // non-power-of-two NUM_ACC; the value is unused then.
  assign nxt_index = out_last ? '0 : out_index + 1'b1;

  // One shared requantizer: in IDLE it converts element 0 straight from the
  // input with the incoming shift, in DRAIN it pre-computes the next element
  // so the registered out_data advances with no bubble.
  assign rq_x     = (state == IDLE) ? acc_in[0 +: ACC_WIDTH] : buffer[nxt_index];
  assign rq_shift = (state == IDLE) ? shift : shift_q;

  requant_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_rq (
    .x    (rq_x),
    .shift(rq_shift),
    .y    (rq_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            buffer    <= acc_in;
            shift_q   <= shift;
            out_data  <= rq_y;
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // out_valid is always high here, so out_ready alone is the handshake.
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              out_index <= nxt_index;
              out_data  <= rq_y;
              out_last  <= (nxt_index == IDX_W'(NUM_ACC-1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_drain_requant.sv
module tb_acc_drain_requant;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int OW = 8;
  localparam int SW = 5;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N*AW-1:0] acc_in;
  logic [SW-1:0] shift;
  logic          mac_clear;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_last;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  acc_drain_requant #(
    .NUM_ACC(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .acc_in   (acc_in),
    .shift    (shift),
    .mac_clear(mac_clear),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Full drain with out_ready high; acc_in/shift are scrambled right after
  // the accept edge to show the snapshot and latched shift are used.
  task automatic run_drain(input logic [AW-1:0] a3, input logic [AW-1:0] a2,
                           input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                           input logic [SW-1:0] sh,
                           input logic [OW-1:0] e3, input logic [OW-1:0] e2,
                           input logic [OW-1:0] e1, input logic [OW-1:0] e0);
    logic [OW-1:0] e [N];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    acc_in = {a3, a2, a1, a0};
    shift = sh;
    out_ready = 1'b1;
    start = 1'b1;
    #1 chk("mac_clear_accept", 32'(mac_clear), 32'd1);
    tick;
    start = 1'b0;
    acc_in = '1;
    shift = '0;
    #1 chk("mac_clear_after", 32'(mac_clear), 32'd0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("index_%0d", i), 32'(out_index), 32'(i));
      chk($sformatf("data_%0d", i),  32'(out_data),  32'(e[i]));
      chk($sformatf("last_%0d", i),  32'(out_last),  32'(i == N-1));
      chk($sformatf("busy_%0d", i),  32'(busy),      32'd1);
      tick;
    end
    chk("valid_done", 32'(out_valid), 32'd0);
    chk("busy_done",  32'(busy),      32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    acc_in = '1;
    shift = '0;
    #1 chk("mac_clear_in_reset", 32'(mac_clear), 32'd0);
    tick;
    tick;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick;
    chk("idle_no_clear", 32'(mac_clear), 32'd0);

    // shift 0: plain saturation
    run_drain(32'd0, 32'd255, 32'd300, 32'd5, 5'd0, 8'd0, 8'd255, 8'd255, 8'd5);

    // shift 4: rounding, and no wrap on the all-ones accumulator
    run_drain(32'hFFFFFFFF, 32'd8, 32'd23, 32'd24, 5'd4, 8'd255, 8'd1, 8'd1, 8'd2);

    // start right after busy fell is accepted; then backpressure on idx 1
    // with start held high during the stall
    acc_in = {32'd40, 32'd30, 32'd20, 32'd10};
    shift = 5'd0;
    start = 1'b1;
    #1 chk("mac_clear_back2back", 32'(mac_clear), 32'd1);
    tick;
    start = 1'b0;
    chk("bp_idx0",  32'(out_index), 32'd0);
    chk("bp_data0", 32'(out_data),  32'd10);
    tick;
    chk("bp_idx1",  32'(out_index), 32'd1);
    chk("bp_data1", 32'(out_data),  32'd20);
    out_ready = 1'b0;
    start = 1'b1;
    #1 chk("mac_clear_busy", 32'(mac_clear), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("stall_idx_%0d", i),   32'(out_index), 32'd1);
      chk($sformatf("stall_data_%0d", i),  32'(out_data),  32'd20);
      chk($sformatf("stall_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall_last_%0d", i),  32'(out_last),  32'd0);
      chk($sformatf("stall_clear_%0d", i), 32'(mac_clear), 32'd0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_idx2",  32'(out_index), 32'd2);
    chk("bp_data2", 32'(out_data),  32'd30);
    tick;
    chk("bp_idx3",  32'(out_index), 32'd3);
    chk("bp_data3", 32'(out_data),  32'd40);
    chk("bp_last3", 32'(out_last),  32'd1);
    tick;
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_done_busy",  32'(busy),      32'd0);

    // reset while presenting idx 2
    acc_in = {32'd4, 32'd3, 32'd2, 32'd1};
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("mid_idx2",  32'(out_index), 32'd2);
    chk("mid_data2", 32'(out_data),  32'd3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_index", 32'(out_index), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_last",  32'(out_last),  32'd0);
    run_drain(32'd8, 32'd7, 32'd6, 32'd5, 5'd0, 8'd8, 8'd7, 8'd6, 8'd5);

    // shift 31: 0xC0000000 rounds 1.5 up to 2, 0x3FFFFFFF rounds to 0
    run_drain(32'd0, 32'd0, 32'h3FFFFFFF, 32'hC0000000, 5'd31, 8'd0, 8'd0, 8'd0, 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
